// File: rtl/spi_flash_erase_ctrl.sv
// SPI-flash erase engine: WREN, erase opcode (+address), then RDSR polling until WIP clears.
// Pin outputs are registered from the next-state values, so they line up with the FSM state.
module spi_flash_erase_ctrl #(
  parameter int CLK_DIV    = 2,
  parameter int ADDR_BYTES = 3,
  parameter int CS_GAP     = 4,
  parameter int POLL_LIMIT = 65535
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [8*ADDR_BYTES-1:0] addr,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    cs_n,
  output logic                    sck,
  output logic                    mosi,
  input  logic                    miso
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int FW = 8 + AW;
  localparam int BW = $clog2(FW + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);
  localparam logic [15:0]   POLL_LAST = 16'(POLL_LIMIT - 1);
  localparam logic [BW-1:0] BITS_OP   = BW'(8);
  localparam logic [BW-1:0] BITS_ST   = BW'(15);
  localparam logic [BW-1:0] BITS_POLL = BW'(16);
  localparam logic [BW-1:0] BITS_ADDR = BW'(FW);
  localparam logic [BW-1:0] ONE_B     = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WREN  = 3'd1,
    S_GAP1  = 3'd2,
    S_ERASE = 3'd3,
    S_GAP2  = 3'd4,
    S_POLL  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t          state_r, state_s;
  logic [DW-1:0]   div_r, div_s;
  logic            ph_r, ph_s;
  logic [BW-1:0]   bit_r, bit_s, nbits_s;
  logic [GW-1:0]   gap_r, gap_s;
  logic [15:0]     poll_r, poll_s;
  logic [7:0]      sr_r, sr_s;
  logic [FW-1:0]   frame_r, frame_s;
  logic [1:0]      mode_r, mode_s;
  logic [AW-1:0]   addr_r, addr_s;
  logic            errp_r, errp_s;
  logic            xfer_s, xfer_end_s, xfer_nxt_s;
  logic            cs_n_s, sck_s, mosi_s, busy_s, done_s, err_s;

  function automatic logic [7:0] erase_op(input logic [1:0] m);
    case (m)
      2'b00:   erase_op = 8'h20;
      2'b01:   erase_op = 8'hD8;
      default: erase_op = 8'hC7;
    endcase
  endfunction

  // State, counters and registered pin/handshake outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r <= S_IDLE;
      div_r   <= '0;
      ph_r    <= 1'b0;
      bit_r   <= '0;
      gap_r   <= '0;
      poll_r  <= 16'd0;
      sr_r    <= 8'd0;
      frame_r <= '0;
      mode_r  <= 2'b00;
      addr_r  <= '0;
      errp_r  <= 1'b0;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      ph_r    <= ph_s;
      bit_r   <= bit_s;
      gap_r   <= gap_s;
      poll_r  <= poll_s;
      sr_r    <= sr_s;
      frame_r <= frame_s;
      mode_r  <= mode_s;
      addr_r  <= addr_s;
      errp_r  <= errp_s;
      cs_n    <= cs_n_s;
      sck     <= sck_s;
      mosi    <= mosi_s;
      busy    <= busy_s;
      done    <= done_s;
      err     <= err_s;
    end
  end

  // Next-state and bit sequencing; a transaction ends after its CLK_DIV-cycle tail
  always_comb begin
    state_s    = state_r;
    div_s      = div_r;
    ph_s       = ph_r;
    bit_s      = bit_r;
    gap_s      = gap_r;
    poll_s     = poll_r;
    sr_s       = sr_r;
    frame_s    = frame_r;
    mode_s     = mode_r;
    addr_s     = addr_r;
    errp_s     = errp_r;
    xfer_end_s = 1'b0;
    xfer_s     = (state_r == S_WREN) || (state_r == S_ERASE) || (state_r == S_POLL);

    case (state_r)
      S_WREN:  nbits_s = BITS_OP;
      S_ERASE: nbits_s = (mode_r == 2'b10) ? BITS_OP : BITS_ADDR;
      S_POLL:  nbits_s = BITS_POLL;
      default: nbits_s = BITS_OP;
    endcase

    if (xfer_s) begin
      if (div_r != DIV_LAST) begin
        div_s = div_r + 1'b1;
      end else begin
        div_s = '0;
        if (bit_r == nbits_s) begin
          bit_s      = '0;
          xfer_end_s = 1'b1;
        end else if (!ph_r) begin
          ph_s = 1'b1;
          sr_s = {sr_r[6:0], miso};
        end else if ((state_r == S_POLL) && (bit_r == BITS_ST)) begin
          // status byte complete: sr_r[0] is WIP
          ph_s   = 1'b0;
          poll_s = poll_r + 16'd1;
          if (!sr_r[0]) begin
            bit_s = BITS_POLL;
          end else if (poll_r == POLL_LAST) begin
            bit_s  = BITS_POLL;
            errp_s = 1'b1;
          end else begin
            bit_s = BITS_OP;
          end
        end else begin
          ph_s    = 1'b0;
          bit_s   = bit_r + ONE_B;
          frame_s = ((bit_r + ONE_B) == nbits_s) ? frame_r : {frame_r[FW-2:0], 1'b0};
        end
      end
    end else begin
      div_s = '0;
      ph_s  = 1'b0;
    end

    case (state_r)
      S_IDLE: begin
        if (start && !done) begin
          mode_s = mode;
          addr_s = addr;
          if (mode == 2'b11) begin
            state_s = S_FIN;
            errp_s  = 1'b1;
          end else begin
            state_s = S_WREN;
            errp_s  = 1'b0;
            frame_s = {8'h06, {AW{1'b0}}};
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WREN:  state_s = xfer_end_s ? S_GAP1 : S_WREN;
      S_GAP1: begin
        if (gap_r == GAP_LAST) begin
          state_s = S_ERASE;
          gap_s   = '0;
          frame_s = (mode_r == 2'b10) ? {8'hC7, {AW{1'b0}}} : {erase_op(mode_r), addr_r};
        end else begin
          gap_s = gap_r + 1'b1;
        end
      end
      S_ERASE: state_s = xfer_end_s ? S_GAP2 : S_ERASE;
      S_GAP2: begin
        if (gap_r == GAP_LAST) begin
          state_s = S_POLL;
          gap_s   = '0;
          poll_s  = 16'd0;
          frame_s = {8'h05, {AW{1'b0}}};
        end else begin
          gap_s = gap_r + 1'b1;
        end
      end
      S_POLL:  state_s = xfer_end_s ? S_FIN : S_POLL;
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode from next-state values; done/err mark the FIN -> IDLE step
  always_comb begin
    xfer_nxt_s = (state_s == S_WREN) || (state_s == S_ERASE) || (state_s == S_POLL);
    cs_n_s     = ~xfer_nxt_s;
    sck_s      = xfer_nxt_s & ph_s;
    mosi_s     = xfer_nxt_s & frame_s[FW-1];
    busy_s     = (state_s != S_IDLE);
    done_s     = (state_r == S_FIN);
    err_s      = (state_r == S_FIN) & errp_r;
  end

endmodule
